// File: rtl/adc_scan_avg_if.sv
// Command/response link between the scan sequencer and the modular ADC core.
//
// Handshake semantics:
//   Command: the master raises CMD_VALID with CMD_CHANNEL and holds both stable
//   until it samples CMD_READY high. The transfer happens on the rising edge
//   where CMD_VALID && CMD_READY. The slave may hold CMD_READY low for any
//   number of cycles.
//   Response: RSP_VALID is a one-cycle pulse with no back-pressure. The master
//   only listens for it while a command is outstanding.
interface adc_scan_avg_if #(
  parameter int DATA_W = 12
);
  logic              CMD_VALID;
  logic [4:0]        CMD_CHANNEL;
  logic              CMD_READY;
  logic              RSP_VALID;
  logic [4:0]        RSP_CHANNEL;
  logic [DATA_W-1:0] RSP_DATA;

  modport master (
    output CMD_VALID, CMD_CHANNEL,
    input  CMD_READY, RSP_VALID, RSP_CHANNEL, RSP_DATA
  );

  modport slave (
    input  CMD_VALID, CMD_CHANNEL,
    output CMD_READY, RSP_VALID, RSP_CHANNEL, RSP_DATA
  );
endinterface

// File: rtl/adc_scan_avg.sv
// Multi-channel ADC scan sequencer with a per-channel power-of-two boxcar
// averager. It issues one command per channel over CH_FIRST..CH_FIRST+NUM_CH-1,
// checks the response tag and emits a raw or averaged sample tagged with its
// channel. It supports single and continuous scans, a response timeout, and a
// sticky error flag.
module adc_scan_avg #(
  parameter int NUM_CH   = 8,
  parameter int CH_FIRST = 1,
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1023
) (
  input  logic              SYS_CLK,
  input  logic              RESET_n,
  input  logic              START,
  input  logic              CONT,
  input  logic              FITER_EN,
  adc_scan_avg_if.master    adc,
  output logic [DATA_W-1:0] DATA,
  output logic [4:0]        DATA_CH,
  output logic              DATA_VALID,
  output logic              BUSY,
  output logic              ERR,
  output logic [1:0]        dbg_state
);

  localparam int D  = 1 << AVG_LOG2;
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SW = DATA_W + AVG_LOG2;
  localparam int FW = AVG_LOG2 + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_WAIT = 2'd2,
    S_CALC = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [4:0]        rsp_ch_q, rsp_ch_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [4:0]        data_ch_q, data_ch_d;
  logic              data_valid_q, data_valid_d;

  // Per-channel history: circular sample buffer, running sum, write pointer
  // (which is also the oldest entry) and saturating fill count.
  logic [DATA_W-1:0] hist_q [NUM_CH][D];
  logic [DATA_W-1:0] hist_d [NUM_CH][D];
  logic [SW-1:0]     sum_q  [NUM_CH];
  logic [SW-1:0]     sum_d  [NUM_CH];
  logic [PW-1:0]     wptr_q [NUM_CH];
  logic [PW-1:0]     wptr_d [NUM_CH];
  logic [FW-1:0]     fill_q [NUM_CH];
  logic [FW-1:0]     fill_d [NUM_CH];

  logic [4:0]        exp_ch;
  logic [DATA_W-1:0] oldest;
  logic [SW-1:0]     sum_new;
  logic [FW-1:0]     fill_new;
  logic [DATA_W-1:0] avg_val;
  logic              advance;

  // Datapath for the channel being processed: new sum, fill count and average.
  always_comb begin
    exp_ch   = 5'(CH_FIRST) + 5'(idx_q);
    oldest   = hist_q[idx_q][wptr_q[idx_q]];
    sum_new  = sum_q[idx_q] + SW'(rsp_data_q) - SW'(oldest);
    fill_new = (fill_q[idx_q] == FW'(D)) ? fill_q[idx_q] : fill_q[idx_q] + 1'b1;
    avg_val  = DATA_W'(sum_new >> AVG_LOG2);
  end

  // Next-state logic for the scan FSM, history update and output strobe.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    rsp_data_d   = rsp_data_q;
    rsp_ch_d     = rsp_ch_q;
    data_d       = data_q;
    data_ch_d    = data_ch_q;
    data_valid_d = 1'b0;
    hist_d       = hist_q;
    sum_d        = sum_q;
    wptr_d       = wptr_q;
    fill_d       = fill_q;
    advance      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // START clears the error; CONT alone also launches a scan.
        if (START) begin
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = S_CMD;
        end else if (CONT) begin
          idx_d   = '0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (adc.CMD_READY) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (adc.RSP_VALID) begin
          rsp_data_d = adc.RSP_DATA;
          rsp_ch_d   = adc.RSP_CHANNEL;
          state_d    = S_CALC;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Response lost: flag it and move on without an output.
          err_d   = 1'b1;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CALC: begin
        advance = 1'b1;
        if (rsp_ch_q != exp_ch) begin
          err_d = 1'b1;
        end else begin
          hist_d[idx_q][wptr_q[idx_q]] = rsp_data_q;
          sum_d[idx_q]  = sum_new;
          fill_d[idx_q] = fill_new;
          wptr_d[idx_q] = (AVG_LOG2 == 0) ? '0 : wptr_q[idx_q] + 1'b1;
          data_valid_d  = 1'b1;
          data_ch_d     = exp_ch;
          data_d        = (FITER_EN && (fill_new == FW'(D))) ? avg_val : rsp_data_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Step to the next channel, wrap in continuous mode, or finish the scan.
    if (advance) begin
      if (idx_q < IW'(NUM_CH - 1)) begin
        idx_d   = idx_q + 1'b1;
        state_d = S_CMD;
      end else if (CONT) begin
        idx_d   = '0;
        state_d = S_CMD;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge SYS_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      rsp_data_q   <= '0;
      rsp_ch_q     <= '0;
      data_q       <= '0;
      data_ch_q    <= '0;
      data_valid_q <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        sum_q[c]  <= '0;
        wptr_q[c] <= '0;
        fill_q[c] <= '0;
        for (int e = 0; e < D; e++) begin
          hist_q[c][e] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      rsp_data_q   <= rsp_data_d;
      rsp_ch_q     <= rsp_ch_d;
      data_q       <= data_d;
      data_ch_q    <= data_ch_d;
      data_valid_q <= data_valid_d;
      hist_q       <= hist_d;
      sum_q        <= sum_d;
      wptr_q       <= wptr_d;
      fill_q       <= fill_d;
    end
  end

  assign adc.CMD_VALID   = (state_q == S_CMD);
  assign adc.CMD_CHANNEL = exp_ch;
  assign DATA            = data_q;
  assign DATA_CH         = data_ch_q;
  assign DATA_VALID      = data_valid_q;
  assign BUSY            = (state_q != S_IDLE);
  assign ERR             = err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_adc_scan_avg.sv
// Directed bench for adc_scan_avg: 4 channels starting at 1, depth 4, short
// timeout. Inputs are driven and outputs sampled on the falling clock edge.
module tb_adc_scan_avg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        fiter_en = 1'b0;
  logic [11:0] data;
  logic [4:0]  data_ch;
  logic        data_valid;
  logic        busy;
  logic        err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Per-channel sample and expected output tables for the averaging run.
  int smp  [4][5] = '{'{4, 8, 12, 16, 20}, '{1, 2, 3, 4, 5},
                      '{9, 9, 9, 9, 1}, '{4095, 4095, 4095, 4095, 4095}};
  int expv [4][5] = '{'{4, 8, 12, 10, 14}, '{1, 2, 3, 2, 3},
                      '{9, 9, 9, 9, 7}, '{4095, 4095, 4095, 4095, 4095}};

  adc_scan_avg_if #(.DATA_W(12)) adc ();

  adc_scan_avg #(
    .NUM_CH(4), .CH_FIRST(1), .DATA_W(12), .AVG_LOG2(2), .TIMEOUT(15)
  ) dut (
    .SYS_CLK(clk), .RESET_n(rst_n), .START(start), .CONT(cont),
    .FITER_EN(fiter_en), .adc(adc), .DATA(data), .DATA_CH(data_ch),
    .DATA_VALID(data_valid), .BUSY(busy), .ERR(err), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Driver: reset pulse with all inputs idle.
  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; cont = 1'b0;
    adc.CMD_READY = 1'b0; adc.RSP_VALID = 1'b0;
    adc.RSP_CHANNEL = '0; adc.RSP_DATA = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Driver: wait for a command, hold ready low for 'hold' cycles, accept it.
  task automatic do_cmd(input int hold, output logic [4:0] ch, output logic ok,
                        output logic stable);
    int n = 0;
    ok = 1'b0; stable = 1'b1; ch = '0;
    while (adc.CMD_VALID !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (adc.CMD_VALID === 1'b1) begin
      ok = 1'b1;
      ch = adc.CMD_CHANNEL;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (adc.CMD_VALID !== 1'b1 || adc.CMD_CHANNEL !== ch) stable = 1'b0;
      end
      adc.CMD_READY = 1'b1;
      @(negedge clk);
      adc.CMD_READY = 1'b0;
    end
  endtask

  // Driver: pulse a response, then watch up to 'max' cycles for the strobe.
  task automatic rsp_and_wait(input logic [4:0] tag, input logic [11:0] d,
                              input int max, output logic found, output int lat,
                              output logic [11:0] od, output logic [4:0] oc);
    found = 1'b0; lat = -1; od = '0; oc = '0;
    adc.RSP_VALID = 1'b1; adc.RSP_CHANNEL = tag; adc.RSP_DATA = d;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      adc.RSP_VALID = 1'b0;
      if (data_valid === 1'b1) begin
        found = 1'b1; lat = i; od = data; oc = data_ch;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (adc.CMD_VALID !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid: got %b want 0", adc.CMD_VALID); end
    checks++; if (adc.CMD_CHANNEL !== 5'd1) begin errors++; $display("FAIL reset_cmd_channel: got %0d want 1", adc.CMD_CHANNEL); end
    checks++; if (data !== 12'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", data); end
    checks++; if (data_ch !== 5'd0) begin errors++; $display("FAIL reset_data_ch: got %0d want 0", data_ch); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_raw_scan();
    logic [4:0] ch, oc; logic ok, st, found; int lat; logic [11:0] od;
    fiter_en = 1'b0; cont = 1'b0;
    pulse_start();
    checks++; if (adc.CMD_VALID !== 1'b1) begin errors++; $display("FAIL raw_start_latency: cmd_valid got %b want 1", adc.CMD_VALID); end
    for (int i = 0; i < 4; i++) begin
      do_cmd(0, ch, ok, st);
      checks++; if (ok !== 1'b1 || ch !== 5'(i + 1)) begin errors++; $display("FAIL raw_cmd_ch: got %0d ok %b want %0d", ch, ok, i + 1); end
      rsp_and_wait(5'(i + 1), 12'((i + 1) * 100), 4, found, lat, od, oc);
      checks++; if (found !== 1'b1 || lat != 2 || od !== 12'((i + 1) * 100) || oc !== 5'(i + 1)) begin
        errors++; $display("FAIL raw_strobe: got lat %0d data %0d ch %0d want lat 2 data %0d ch %0d", lat, od, oc, (i + 1) * 100, i + 1);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL raw_busy_end: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    checks++; if (data !== 12'd400 || data_ch !== 5'd4 || data_valid !== 1'b0) begin
      errors++; $display("FAIL raw_hold: got data %0d ch %0d dv %b want 400 4 0", data, data_ch, data_valid);
    end
  endtask

  task automatic test_cmd_stall();
    logic [4:0] ch, oc; logic ok, st, found; int lat; logic [11:0] od;
    fiter_en = 1'b0; cont = 1'b0;
    pulse_start();
    do_cmd(5, ch, ok, st);
    checks++; if (ok !== 1'b1 || ch !== 5'd1 || st !== 1'b1) begin errors++; $display("FAIL stall_stable: got ch %0d ok %b stable %b want 1 1 1", ch, ok, st); end
    checks++; if (adc.CMD_VALID !== 1'b0) begin errors++; $display("FAIL stall_cmd_drop: got %b want 0", adc.CMD_VALID); end
    rsp_and_wait(5'd1, 12'd55, 4, found, lat, od, oc);
    checks++; if (found !== 1'b1 || od !== 12'd55 || oc !== 5'd1) begin errors++; $display("FAIL stall_strobe: got data %0d ch %0d want 55 1", od, oc); end
    for (int i = 1; i < 4; i++) begin
      do_cmd(0, ch, ok, st);
      rsp_and_wait(5'(i + 1), 12'd7, 4, found, lat, od, oc);
      checks++; if (found !== 1'b1 || oc !== 5'(i + 1)) begin errors++; $display("FAIL stall_rest: got ch %0d found %b want %0d", oc, found, i + 1); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_avg_cont();
    logic [4:0] ch, oc; logic ok, st, found; int lat; logic [11:0] od;
    apply_reset();
    fiter_en = 1'b1; cont = 1'b1;
    for (int r = 0; r < 5; r++) begin
      if (r == 4) cont = 1'b0;
      for (int c = 0; c < 4; c++) begin
        do_cmd(0, ch, ok, st);
        checks++; if (ok !== 1'b1 || ch !== 5'(c + 1)) begin errors++; $display("FAIL avg_cmd_ch: round %0d got %0d want %0d", r, ch, c + 1); end
        rsp_and_wait(5'(c + 1), 12'(smp[c][r]), 4, found, lat, od, oc);
        checks++; if (found !== 1'b1 || od !== 12'(expv[c][r]) || oc !== 5'(c + 1)) begin
          errors++; $display("FAIL avg_out: round %0d ch %0d got %0d want %0d", r, c + 1, od, expv[c][r]);
        end
        if (c == 3 && r < 4) begin
          checks++; if (busy !== 1'b1 || adc.CMD_VALID !== 1'b1 || adc.CMD_CHANNEL !== 5'd1) begin
            errors++; $display("FAIL avg_wrap: got busy %b cmd_valid %b ch %0d want 1 1 1", busy, adc.CMD_VALID, adc.CMD_CHANNEL);
          end
        end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL avg_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_tag_err();
    logic [4:0] ch, oc; logic ok, st, found; int lat; logic [11:0] od;
    fiter_en = 1'b0; cont = 1'b0;
    pulse_start();
    do_cmd(0, ch, ok, st);
    rsp_and_wait(5'd1, 12'd11, 4, found, lat, od, oc);
    do_cmd(0, ch, ok, st);
    rsp_and_wait(5'd3, 12'd22, 3, found, lat, od, oc);
    checks++; if (found !== 1'b0) begin errors++; $display("FAIL tag_no_strobe: got strobe ch %0d want none", oc); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tag_err_set: got %b want 1", err); end
    do_cmd(0, ch, ok, st);
    checks++; if (ok !== 1'b1 || ch !== 5'd3) begin errors++; $display("FAIL tag_next_ch: got %0d want 3", ch); end
    rsp_and_wait(5'd3, 12'd33, 4, found, lat, od, oc);
    do_cmd(0, ch, ok, st);
    rsp_and_wait(5'd4, 12'd44, 4, found, lat, od, oc);
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL tag_sticky: got err %b busy %b want 1 0", err, busy); end
    pulse_start();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tag_start_clear: got %b want 0", err); end
    for (int i = 0; i < 4; i++) begin
      do_cmd(0, ch, ok, st);
      rsp_and_wait(5'(i + 1), 12'd5, 4, found, lat, od, oc);
    end
  endtask

  task automatic test_timeout();
    logic [4:0] ch, oc; logic ok, st, found, saw_dv; int lat, waited; logic [11:0] od;
    fiter_en = 1'b0; cont = 1'b0;
    pulse_start();
    do_cmd(0, ch, ok, st);
    waited = 0; saw_dv = 1'b0;
    while (err !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
      if (data_valid === 1'b1) saw_dv = 1'b1;
    end
    checks++; if (waited != 15) begin errors++; $display("FAIL timeout_cycles: got %0d want 15", waited); end
    checks++; if (saw_dv !== 1'b0) begin errors++; $display("FAIL timeout_no_strobe: got strobe want none"); end
    do_cmd(0, ch, ok, st);
    checks++; if (ok !== 1'b1 || ch !== 5'd2) begin errors++; $display("FAIL timeout_next_ch: got %0d want 2", ch); end
    rsp_and_wait(5'd2, 12'd202, 4, found, lat, od, oc);
    for (int i = 2; i < 4; i++) begin
      do_cmd(0, ch, ok, st);
      rsp_and_wait(5'(i + 1), 12'd303, 4, found, lat, od, oc);
    end
    checks++; if (busy !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL timeout_end: got busy %b err %b want 0 1", busy, err); end
  endtask

  task automatic test_reset_mid();
    logic [4:0] ch, oc; logic ok, st, found; int lat; logic [11:0] od;
    fiter_en = 1'b1; cont = 1'b0;
    pulse_start();
    do_cmd(0, ch, ok, st);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || adc.CMD_VALID !== 1'b0 || adc.CMD_CHANNEL !== 5'd1) begin
      errors++; $display("FAIL rmid_ctrl: got busy %b cmd_valid %b ch %0d want 0 0 1", busy, adc.CMD_VALID, adc.CMD_CHANNEL);
    end
    checks++; if (data !== 12'd0 || data_ch !== 5'd0 || data_valid !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rmid_outputs: got data %0d ch %0d dv %b err %b want 0 0 0 0", data, data_ch, data_valid, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rsp_and_wait(5'd1, 12'd999, 3, found, lat, od, oc);
    checks++; if (found !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_late_rsp: got strobe %b busy %b want 0 0", found, busy); end
    pulse_start();
    do_cmd(0, ch, ok, st);
    checks++; if (ok !== 1'b1 || ch !== 5'd1) begin errors++; $display("FAIL rmid_restart_ch: got %0d want 1", ch); end
    rsp_and_wait(5'd1, 12'd1000, 4, found, lat, od, oc);
    checks++; if (found !== 1'b1 || od !== 12'd1000 || oc !== 5'd1) begin errors++; $display("FAIL rmid_fill_cleared: got %0d want 1000", od); end
    for (int i = 1; i < 4; i++) begin
      do_cmd(0, ch, ok, st);
      rsp_and_wait(5'(i + 1), 12'd8, 4, found, lat, od, oc);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy_end: got %b want 0", busy); end
  endtask

  initial begin
    adc.CMD_READY = 1'b0; adc.RSP_VALID = 1'b0;
    adc.RSP_CHANNEL = '0; adc.RSP_DATA = '0;
    test_reset();
    test_raw_scan();
    test_cmd_stall();
    test_avg_cont();
    test_tag_err();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
